chuchu_ckpt_ctrl: RTL and testbench
===================================

# chuchu_ckpt_ctrl

Checkpoint controller that drives the save/restore port of the `chuchu` rename free-list. It hands out checkpoint pages 0..7 to dispatching branches and issues `save_state`/`save_page` pulses. On branch resolution it either releases the page or issues `restore_state`/`restore_page` and squashes all younger checkpoints. It sits between branch dispatch/resolve logic and `chuchu`, and is the initiator for the page-save/restore requests that `chuchu` services.

## Interface
- NUM_PAGES, 8: checkpoint pages; fixed to 8 in this revision.
- PAGE_W, 3: page index width.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately while low.
- br_valid  in  1  dispatching branch requests a checkpoint.
- br_ready  out  1  request accepted when br_valid && br_ready at a rising edge.
- br_page  out  3  page granted; valid in the accept cycle; equals the tail pointer.
- resolve_valid  in  1  branch resolution presented.
- resolve_page  in  3  page of the resolving branch.
- resolve_mispredict  in  1  1 = restore and squash, 0 = release only.
- resolve_ready  out  1  resolution accepted when resolve_valid && resolve_ready at an edge.
- save_state  out  1  registered pulse to `chuchu`.
- save_page  out  3  registered; held stable across the pulse and the following cycle.
- restore_state  out  1  registered pulse to `chuchu`.
- restore_page  out  3  registered; held like save_page.
- live_count  out  4  number of valid pages, 0..8.
- resolve_err  out  1  one-cycle pulse when an accepted resolve names an invalid page.

## Operation
- State:
  - valid[7:0] bitmap
  - tail pointer (3 bits, wraps 7→0)
  - FSM {IDLE, SAVE, SAVE_HOLD, RST, RST_HOLD}
- Allocation is strictly circular. A page is granted only at tail.
- br_ready = (FSM==IDLE) && !valid[tail] && !resolve_valid. A resolve in the same cycle always wins.
- resolve_ready = (FSM==IDLE).
- Branch accept: set valid[tail], tail←tail+1, FSM→SAVE, latch save_page←old tail.
- SAVE: save_state=1, then →SAVE_HOLD. SAVE_HOLD: save_state=0 with page unchanged (`chuchu` drops its write enable on the falling edge using save_page), then →IDLE.
- Correct resolve (mispredict=0) on a valid page: clear valid[resolve_page]. The FSM stays IDLE, tail is unchanged, and there is no pulse.
- Mispredict resolve on a valid page:
  - Clear resolve_page and every page after it circularly, stopping before tail.
  - If resolve_page==tail with live_count==8, clear all 8.
  - Set tail←resolve_page and latch restore_page←resolve_page.
  - FSM→RST (restore_state=1) →RST_HOLD (0, page held) →IDLE.
- Resolve on an invalid page, either kind: no state change; resolve_err pulses in the next cycle.
- Out-of-order releases leave holes. If valid[tail] is still set, br_ready stays low even when other pages are free. This is intended, because it preserves age order.
- live_count = popcount(valid), registered alongside valid.

## Timing
- Reset (low) values:
  - br_ready=0, resolve_ready=0 while reset is low.
  - save_state=0, restore_state=0, save_page=0, restore_page=0.
  - live_count=0, resolve_err=0, valid=0, tail=0, FSM=IDLE.
- The first accept is possible at the first edge after reset deasserts.
- Branch accepted at edge N:
  - br_page is valid combinationally during cycle N.
  - save_state is high in cycle N+1 and low in N+2.
  - save_page is valid N+1..N+2 and holds afterward.
  - br_ready can reassert in N+3.
  - live_count increments at edge N.
- Mispredict accepted at edge N:
  - valid, tail and live_count are updated at edge N.
  - restore_state is high in N+1; restore_page is valid N+1..N+2.
  - resolve_ready/br_ready return in N+3.
- Minimum spacing between any two pulses is 3 cycles. save_state and restore_state are never high together.
- Reset asserted mid-pulse: outputs drop to 0 asynchronously. No completion is attempted.

## Test plan
- Reset release, then 8 back-to-back br_valid:
  - Grants pages 0..7, each followed by a save_state pulse.
  - live_count=8 and br_ready=0 after the 8th grant.
  - Grant edges are 3 cycles apart.
- Allocate 0..3, correct-resolve page 1, then br_valid:
  - Grants page 4.
  - live_count goes 4→3→4.
  - No restore_state pulse.
- Allocate 0..5, mispredict page 2:
  - restore_state is high 1 cycle with restore_page=2 held 2 cycles.
  - valid=8'b0000_0011, live_count=2, tail=2.
  - The next grant is page 2.
- Fill all 8 pages, release pages 1..7 correctly, leave page 0:
  - br_ready stays 0 because valid[tail=0] is set.
  - Releasing page 0 gives br_ready=1 and a grant of page 0.
- Same-cycle br_valid and a mispredict resolve in IDLE:
  - The resolve is accepted and the branch is not.
  - The branch is granted 3 cycles later at the new tail.
- Resolve to invalid page 6 with live_count=2:
  - resolve_err pulses 1 cycle; state is unchanged.
- Assert reset low during SAVE:
  - save_state drops immediately.
  - After release, all outputs are 0 and the first grant is page 0.

Source files
------------

// File: rtl/chuchu_ckpt_ctrl_if.sv
// Branch-side and chuchu-side signals of the checkpoint controller.
//   br_*       : dispatch handshake, a page is granted at tail
//   resolve_*  : branch resolution handshake plus resolve_err pulse
//   save_*     : save request toward chuchu (pulse + held page)
//   restore_*  : restore request toward chuchu (pulse + held page)
//   live_count : number of live checkpoint pages
// master = dispatch/resolve side and chuchu observer, slave = controller.
interface chuchu_ckpt_ctrl_if #(
   parameter int PAGE_W = 3
);
   logic              br_valid;
   logic              br_ready;
   logic [PAGE_W-1:0] br_page;
   logic              resolve_valid;
   logic [PAGE_W-1:0] resolve_page;
   logic              resolve_mispredict;
   logic              resolve_ready;
   logic              resolve_err;
   logic              save_state;
   logic [PAGE_W-1:0] save_page;
   logic              restore_state;
   logic [PAGE_W-1:0] restore_page;
   logic [3:0]        live_count;

   modport master (
      output br_valid, resolve_valid, resolve_page, resolve_mispredict,
      input  br_ready, br_page, resolve_ready, resolve_err,
      input  save_state, save_page, restore_state, restore_page, live_count
   );

   modport slave (
      input  br_valid, resolve_valid, resolve_page, resolve_mispredict,
      output br_ready, br_page, resolve_ready, resolve_err,
      output save_state, save_page, restore_state, restore_page, live_count
   );
endinterface

// File: rtl/chuchu_ckpt_ctrl.sv
// Checkpoint controller for the chuchu rename free-list. Allocates pages
// circularly at tail, issues save/restore pulses (one cycle high, page held
// one more cycle) and squashes younger pages on a mispredict.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   ckpt  : chuchu_ckpt_ctrl_if.slave (dispatch, resolve, save/restore)
module chuchu_ckpt_ctrl #(
   parameter int NUM_PAGES = 8,
   parameter int PAGE_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   chuchu_ckpt_ctrl_if.slave  ckpt
);
   typedef enum logic [2:0] {
      S_IDLE, S_SAVE, S_SAVE_HOLD, S_RST, S_RST_HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [NUM_PAGES-1:0]  valid_q, valid_d, sq_mask;
   logic [PAGE_W-1:0]     tail_q, tail_d;
   logic [PAGE_W-1:0]     save_page_q, save_page_d;
   logic [PAGE_W-1:0]     rst_page_q, rst_page_d;
   logic [PAGE_W-1:0]     idx;
   logic [3:0]            live_q, live_d;
   logic                  save_q, save_d, rest_q, rest_d, err_q, err_d;
   logic                  stop, idle, br_acc, rs_acc, rs_hit;

   assign idle = (state_q == S_IDLE);

   // Handshakes are gated by reset so nothing reports ready while held.
   // A pending resolve always blocks the branch in the same cycle.
   assign ckpt.br_ready      = reset && idle && !valid_q[tail_q] && !ckpt.resolve_valid;
   assign ckpt.resolve_ready = reset && idle;
   assign ckpt.br_page       = tail_q;

   assign br_acc = ckpt.br_valid && ckpt.br_ready;
   assign rs_acc = ckpt.resolve_valid && ckpt.resolve_ready;
   assign rs_hit = valid_q[ckpt.resolve_page];

   assign ckpt.save_state    = save_q;
   assign ckpt.save_page     = save_page_q;
   assign ckpt.restore_state = rest_q;
   assign ckpt.restore_page  = rst_page_q;
   assign ckpt.live_count    = live_q;
   assign ckpt.resolve_err   = err_q;

   // Squash mask: resolve_page and everything younger, walking circularly
   // and stopping before tail. When resolve_page == tail the walk never
   // meets tail again, so all pages are cleared (the full-ring case).
   always_comb begin
      sq_mask = '0;
      stop    = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_PAGES; i++) begin
         idx = ckpt.resolve_page + PAGE_W'(i);
         if (i != 0 && idx == tail_q) stop = 1'b1;
         if (!stop) sq_mask[idx] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      tail_d      = tail_q;
      save_page_d = save_page_q;
      rst_page_d  = rst_page_q;
      save_d      = 1'b0;
      rest_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rs_acc) begin
               if (!rs_hit) begin
                  err_d = 1'b1;
               end else if (ckpt.resolve_mispredict) begin
                  valid_d    = valid_q & ~sq_mask;
                  tail_d     = ckpt.resolve_page;
                  rst_page_d = ckpt.resolve_page;
                  rest_d     = 1'b1;
                  state_d    = S_RST;
               end else begin
                  valid_d[ckpt.resolve_page] = 1'b0;
               end
            end else if (br_acc) begin
               valid_d[tail_q] = 1'b1;
               tail_d          = tail_q + PAGE_W'(1);
               save_page_d     = tail_q;
               save_d          = 1'b1;
               state_d         = S_SAVE;
            end
         end
         S_SAVE:      state_d = S_SAVE_HOLD;
         S_SAVE_HOLD: state_d = S_IDLE;
         S_RST:       state_d = S_RST_HOLD;
         S_RST_HOLD:  state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      live_d = '0;
      for (int i = 0; i < NUM_PAGES; i++) live_d = live_d + 4'(valid_d[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         tail_q      <= '0;
         save_page_q <= '0;
         rst_page_q  <= '0;
         live_q      <= '0;
         save_q      <= 1'b0;
         rest_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tail_q      <= tail_d;
         save_page_q <= save_page_d;
         rst_page_q  <= rst_page_d;
         live_q      <= live_d;
         save_q      <= save_d;
         rest_q      <= rest_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_chuchu_ckpt_ctrl.sv
// Scoreboard bench for chuchu_ckpt_ctrl: stimulus pushes expected events
// (grant, save pulse, restore pulse, resolve_err pulse); a monitor pops and
// compares whenever the DUT presents one of them.
module tb_chuchu_ckpt_ctrl;
   localparam logic [1:0] K_GNT = 2'd0, K_SAV = 2'd1, K_RST = 2'd2, K_ERR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [2:0] page;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;
   int   cyc = 0;
   ev_t  sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   chuchu_ckpt_ctrl_if #(.PAGE_W(3)) bus ();

   chuchu_ckpt_ctrl #(.NUM_PAGES(8), .PAGE_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .ckpt  (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sb_push(input logic [1:0] k, input logic [2:0] p);
      ev_t e;
      e.kind = k;
      e.page = p;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [1:0] k, input logic [2:0] p);
      ev_t e;
      if (sb_q.size() == 0) begin
         n_run++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d page %0d, expected none (t=%0t)", k, p, $time);
      end else begin
         e = sb_q.pop_front();
         chk("event_kind", 32'(k), 32'(e.kind));
         chk("event_page", 32'(p), 32'(e.page));
      end
   endtask

   // Monitor: event stream plus hold-cycle checks on save/restore pages.
   logic       s_hold = 1'b0, r_hold = 1'b0;
   logic [2:0] s_pg = '0, r_pg = '0;
   always @(negedge clk) begin
      if (s_hold) begin
         chk("save_hold_low", 32'(bus.save_state), 0);
         chk("save_hold_page", 32'(bus.save_page), 32'(s_pg));
      end
      if (r_hold) begin
         chk("restore_hold_low", 32'(bus.restore_state), 0);
         chk("restore_hold_page", 32'(bus.restore_page), 32'(r_pg));
      end
      s_hold = bus.save_state;
      s_pg   = bus.save_page;
      r_hold = bus.restore_state;
      r_pg   = bus.restore_page;
      if (bus.save_state && bus.restore_state) chk("save_restore_excl", 1, 0);
      if (bus.resolve_err) sb_pop(K_ERR, 3'd0);
      if (bus.br_valid && bus.br_ready) sb_pop(K_GNT, bus.br_page);
      if (bus.save_state) sb_pop(K_SAV, bus.save_page);
      if (bus.restore_state) sb_pop(K_RST, bus.restore_page);
   end

   // All stimulus tasks start and end just after a rising edge.
   task automatic do_reset();
      bus.br_valid      = 1'b0;
      bus.resolve_valid = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic alloc(input int n, input int first);
      int got = 0, last = -1, guard = 0;
      for (int i = 0; i < n; i++) begin
         sb_push(K_GNT, 3'((first + i) % 8));
         sb_push(K_SAV, 3'((first + i) % 8));
      end
      bus.br_valid = 1'b1;
      while (got < n && guard < 100) begin
         @(negedge clk);
         guard++;
         if (bus.br_ready) begin
            if (last >= 0) chk("grant_spacing", 32'(cyc + 1 - last), 3);
            last = cyc + 1;
            got++;
            if (got < n) @(posedge clk);
         end
      end
      if (got < n) chk("alloc_timeout", 32'(got), 32'(n));
      @(posedge clk);
      #1 bus.br_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [2:0] p, input logic mis, input logic err);
      int guard = 0;
      if (err) sb_push(K_ERR, 3'd0);
      else if (mis) sb_push(K_RST, p);
      bus.resolve_valid      = 1'b1;
      bus.resolve_page       = p;
      bus.resolve_mispredict = mis;
      @(negedge clk);
      while (!bus.resolve_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("resolve_timeout", 0, 1);
      @(posedge clk);
      #1 bus.resolve_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, guard;
      bus.br_valid = 1'b0;
      bus.resolve_valid = 1'b0;
      bus.resolve_page = '0;
      bus.resolve_mispredict = 1'b0;

      // Reset values while held low
      repeat (2) @(posedge clk);
      #1;
      chk("rst_br_ready", 32'(bus.br_ready), 0);
      chk("rst_resolve_ready", 32'(bus.resolve_ready), 0);
      chk("rst_save", 32'({bus.save_state, bus.save_page}), 0);
      chk("rst_restore", 32'({bus.restore_state, bus.restore_page}), 0);
      chk("rst_live", 32'(bus.live_count), 0);
      chk("rst_err", 32'(bus.resolve_err), 0);
      reset = 1'b1;
      #1 chk("post_rst_br_ready", 32'(bus.br_ready), 1);

      // 8 back-to-back grants
      alloc(8, 0);
      chk("full_live", 32'(bus.live_count), 8);
      chk("full_br_ready", 32'(bus.br_ready), 0);

      // Correct resolve, then next grant at tail
      do_reset();
      alloc(4, 0);
      chk("cr_live4", 32'(bus.live_count), 4);
      resolve(3'd1, 1'b0, 1'b0);
      chk("cr_live3", 32'(bus.live_count), 3);
      alloc(1, 4);
      chk("cr_live4b", 32'(bus.live_count), 4);

      // Mispredict page 2 of 0..5
      do_reset();
      alloc(6, 0);
      resolve(3'd2, 1'b1, 1'b0);
      chk("mp_live", 32'(bus.live_count), 2);
      alloc(1, 2);
      chk("mp_live_after", 32'(bus.live_count), 3);

      // Holes: page 0 left at tail blocks allocation
      do_reset();
      alloc(8, 0);
      for (int p = 1; p < 8; p++) resolve(3'(p), 1'b0, 1'b0);
      chk("hole_live", 32'(bus.live_count), 1);
      chk("hole_br_ready", 32'(bus.br_ready), 0);
      resolve(3'd0, 1'b0, 1'b0);
      chk("hole_br_ready_free", 32'(bus.br_ready), 1);
      alloc(1, 0);

      // Same-cycle branch and mispredict: resolve wins
      do_reset();
      alloc(4, 0);
      sb_push(K_RST, 3'd1);
      sb_push(K_GNT, 3'd1);
      sb_push(K_SAV, 3'd1);
      bus.br_valid = 1'b1;
      bus.resolve_valid = 1'b1;
      bus.resolve_page = 3'd1;
      bus.resolve_mispredict = 1'b1;
      @(negedge clk);
      chk("sc_br_ready", 32'(bus.br_ready), 0);
      chk("sc_resolve_ready", 32'(bus.resolve_ready), 1);
      t0 = cyc + 1;
      @(posedge clk);
      #1 bus.resolve_valid = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus.br_ready && guard < 20);
      chk("sc_grant_gap", 32'(cyc + 1 - t0), 3);
      @(posedge clk);
      #1 bus.br_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("sc_live", 32'(bus.live_count), 2);

      // Resolve to invalid page 6 with two live pages
      resolve(3'd6, 1'b1, 1'b1);
      chk("err_live", 32'(bus.live_count), 2);
      alloc(1, 2);

      // Reset during SAVE
      do_reset();
      sb_push(K_GNT, 3'd0);
      bus.br_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 bus.br_valid = 1'b0;
      chk("mid_save_high", 32'(bus.save_state), 1);
      reset = 1'b0;
      #1;
      chk("mid_save_drop", 32'(bus.save_state), 0);
      chk("mid_live_drop", 32'(bus.live_count), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_outputs", 32'({bus.save_state, bus.save_page, bus.restore_state,
                              bus.restore_page, bus.live_count, bus.resolve_err}), 0);
      alloc(1, 0);

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
